// File: rtl/instr_decode.sv
// Decode stage: splits 16-bit RISC instructions into ALU opcode, register selects, immediate and write-enable.
// Latency: fields and the O_en pulse are registered at the accepting rising edge and hold for one cycle.
// Backpressure: O_instr_ready drops on I_flush, and on RAW/WAW hazards when DECODE_SCOREBOARD_EN is defined.
module instr_decode (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_instr_valid,
  input  logic [15:0] I_instr,
  output logic        O_instr_ready,
  input  logic        I_flush,
  input  logic        I_wb_valid,
  input  logic [2:0]  I_wb_sel,
  output logic        O_en,
  output logic [4:0]  O_aluop,
  output logic [2:0]  O_selD,
  output logic [2:0]  O_selA,
  output logic [2:0]  O_selB,
  output logic [7:0]  O_imm,
  output logic        O_regwe,
  output logic        O_illegal
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_LOAD = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_JMPA = 4'd12;
  localparam logic [3:0] OP_JMPR = 4'd13;

  // Everything the issue logic needs to know about the presented instruction.
  typedef struct packed {
    logic [4:0] aluop;
    logic [2:0] sel_d;
    logic [2:0] sel_a;
    logic [2:0] sel_b;
    logic [7:0] imm;
    logic       legal;
    logic       regwe;
    logic       rd_a;
    logic       rd_b;
  } dec_t;

  dec_t dec;
  logic stall;
  logic accept;

  // Field split and opcode classification (writes, sources read, legality).
  always_comb begin
    dec.aluop = {I_instr[15:12], I_instr[8]};
    dec.sel_d = I_instr[11:9];
    dec.sel_a = I_instr[7:5];
    dec.sel_b = I_instr[4:2];
    dec.imm   = I_instr[7:0];
    dec.legal = 1'b1;
    dec.regwe = 1'b0;
    dec.rd_a  = 1'b1;
    dec.rd_b  = 1'b1;
    case (I_instr[15:12])
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_CMP, OP_SHL, OP_SHR: begin
        dec.regwe = 1'b1;
      end
      OP_NOT: begin
        dec.regwe = 1'b1;
        dec.rd_b  = 1'b0;
      end
      OP_LOAD: begin
        dec.regwe = 1'b1;
        dec.rd_a  = 1'b0;
        dec.rd_b  = 1'b0;
      end
      OP_JMPA: begin
        // Absolute jump only consults rA when the flag bit selects a register target.
        dec.rd_a = I_instr[8];
        dec.rd_b = 1'b0;
      end
      OP_JMPR: begin
        dec.regwe = 1'b0;
      end
      default: begin
        // Undefined opcodes are still consumed (so fetch does not wedge) but never execute.
        dec.legal = 1'b0;
      end
    endcase
  end

`ifdef DECODE_SCOREBOARD_EN
  logic [7:0] busy;
  logic [7:0] busy_set;
  logic [7:0] busy_clr;

  // Hazard check against destinations still in flight; a retire only helps from the next cycle.
  always_comb begin
    stall = 1'b0;
    if (dec.rd_a && busy[dec.sel_a]) stall = 1'b1;
    if (dec.rd_b && busy[dec.sel_b]) stall = 1'b1;
    if (dec.regwe && busy[dec.sel_d]) stall = 1'b1;
  end

  // One-hot set on issue of a writing instruction, one-hot clear on writeback.
  always_comb begin
    busy_set = 8'd0;
    busy_clr = 8'd0;
    if (accept && dec.regwe) busy_set[dec.sel_d] = 1'b1;
    if (I_wb_valid) busy_clr[I_wb_sel] = 1'b1;
  end

  // Pending-destination bits; a new issue to the same register outranks its retire.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      busy <= 8'd0;
    end else begin
      busy <= (busy & ~busy_clr) | busy_set;
    end
  end
`else
  // Without tracking, ordering of dependent instructions is left to software.
  assign stall = 1'b0;

  logic unused_sb;
  assign unused_sb = ^{I_wb_valid, I_wb_sel, dec.rd_a, dec.rd_b};
`endif

  assign O_instr_ready = !I_flush && !stall;
  assign accept        = I_instr_valid && O_instr_ready && !I_flush;

  // Output registers: load on accept, otherwise only the pulse-type outputs drop.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_en      <= 1'b0;
      O_aluop   <= 5'd0;
      O_selD    <= 3'd0;
      O_selA    <= 3'd0;
      O_selB    <= 3'd0;
      O_imm     <= 8'd0;
      O_regwe   <= 1'b0;
      O_illegal <= 1'b0;
    end else if (accept) begin
      O_en    <= dec.legal;
      O_regwe <= dec.regwe;
      O_aluop <= dec.aluop;
      O_selD  <= dec.sel_d;
      O_selA  <= dec.sel_a;
      O_selB  <= dec.sel_b;
      O_imm   <= dec.imm;
      if (!dec.legal) O_illegal <= 1'b1;
    end else begin
      O_en    <= 1'b0;
      O_regwe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: directed vectors, an opcode-table model checked every falling edge,
// plus literal expectations for the documented example instructions.
// Scoreboard scenarios run only when DECODE_SCOREBOARD_EN is defined for the build.
module tb_instr_decode;

`ifdef DECODE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        I_clk = 1'b0;
  logic        I_rst_n = 1'b1;
  logic        I_instr_valid = 1'b0;
  logic [15:0] I_instr = 16'h0000;
  logic        I_flush = 1'b0;
  logic        I_wb_valid = 1'b0;
  logic [2:0]  I_wb_sel = 3'd0;
  logic        O_instr_ready;
  logic        O_en;
  logic [4:0]  O_aluop;
  logic [2:0]  O_selD;
  logic [2:0]  O_selA;
  logic [2:0]  O_selB;
  logic [7:0]  O_imm;
  logic        O_regwe;
  logic        O_illegal;

  instr_decode dut (
    .I_clk         (I_clk),
    .I_rst_n       (I_rst_n),
    .I_instr_valid (I_instr_valid),
    .I_instr       (I_instr),
    .O_instr_ready (O_instr_ready),
    .I_flush       (I_flush),
    .I_wb_valid    (I_wb_valid),
    .I_wb_sel      (I_wb_sel),
    .O_en          (O_en),
    .O_aluop       (O_aluop),
    .O_selD        (O_selD),
    .O_selA        (O_selA),
    .O_selB        (O_selB),
    .O_imm         (O_imm),
    .O_regwe       (O_regwe),
    .O_illegal     (O_illegal)
  );

  always #5 I_clk = ~I_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode tables: bit n set means opcode n is defined / writes rD.
  logic [15:0] legal_map = 16'h3F3F;
  logic [15:0] write_map = 16'h0F3F;

  // Model state: what the ALU should see this cycle.
  bit       m_en = 0, m_regwe = 0, m_ill = 0;
  bit [4:0] m_aluop = 0;
  bit [2:0] m_d = 0, m_a = 0, m_b = 0;
  bit [7:0] m_imm = 0;
  bit [7:0] m_busy = 0;

  function automatic bit m_hazard(input logic [15:0] ins, input bit [7:0] busy);
    logic [3:0] op;
    bit ra, rb, wr;
    op = ins[15:12];
    ra = (op != 4'd8) && ((op != 4'd12) || ins[8]);
    rb = (op != 4'd8) && (op != 4'd5) && (op != 4'd12);
    wr = write_map[op];
    return SB && ((ra && busy[ins[7:5]]) || (rb && busy[ins[4:2]]) || (wr && busy[ins[11:9]]));
  endfunction

  // Reference model updated on the same edges as the design.
  always @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      m_en = 0; m_regwe = 0; m_ill = 0; m_aluop = 0;
      m_d = 0; m_a = 0; m_b = 0; m_imm = 0; m_busy = 0;
    end else begin
      bit acc;
      bit [7:0] nb;
      logic [3:0] op;
      op  = I_instr[15:12];
      acc = I_instr_valid && !I_flush && !m_hazard(I_instr, m_busy);
      nb  = m_busy;
      if (SB && I_wb_valid) nb[I_wb_sel] = 1'b0;
      if (acc) begin
        m_en    = legal_map[op];
        m_regwe = write_map[op];
        m_aluop = {I_instr[15:12], I_instr[8]};
        m_d     = I_instr[11:9];
        m_a     = I_instr[7:5];
        m_b     = I_instr[4:2];
        m_imm   = I_instr[7:0];
        if (!legal_map[op]) m_ill = 1'b1;
        if (SB && write_map[op]) nb[I_instr[11:9]] = 1'b1;
      end else begin
        m_en    = 1'b0;
        m_regwe = 1'b0;
      end
      m_busy = nb;
    end
  end

  // Compare every falling edge, where the ALU samples.
  always @(negedge I_clk) begin
    chk("ready",   O_instr_ready, !I_flush && !m_hazard(I_instr, m_busy));
    chk("en",      O_en,      m_en);
    chk("regwe",   O_regwe,   m_regwe);
    chk("illegal", O_illegal, m_ill);
    chk("aluop",   O_aluop,   m_aluop);
    chk("selD",    O_selD,    m_d);
    chk("selA",    O_selA,    m_a);
    chk("selB",    O_selB,    m_b);
    chk("imm",     O_imm,     m_imm);
  end

  task automatic drive(input logic v, input logic [15:0] ins, input logic fl,
                       input logic wbv, input logic [2:0] wbs);
    I_instr_valid = v;
    I_instr       = ins;
    I_flush       = fl;
    I_wb_valid    = wbv;
    I_wb_sel      = wbs;
    @(posedge I_clk);
    #1;
  endtask

  logic [15:0] stream [8] = '{16'h1234, 16'h2468, 16'h5E00, 16'h9FFC,
                              16'hA123, 16'hB456, 16'hC100, 16'h4ABC};

  initial begin
    #1 I_rst_n = 1'b0;
    #2;
    chk("rst_en",      O_en,          1'b0);
    chk("rst_aluop",   O_aluop,       5'd0);
    chk("rst_selD",    O_selD,        3'd0);
    chk("rst_regwe",   O_regwe,       1'b0);
    chk("rst_illegal", O_illegal,     1'b0);
    chk("rst_ready",   O_instr_ready, 1'b1);
    @(negedge I_clk);
    #2 I_rst_n = 1'b1;

    // Add r5 <- r2, r5
    drive(1'b1, 16'h0A54, 1'b0, 1'b0, 3'd0);
    chk("add_en",    O_en,    1'b1);
    chk("add_aluop", O_aluop, 5'b00000);
    chk("add_selD",  O_selD,  3'd5);
    chk("add_selA",  O_selA,  3'd2);
    chk("add_selB",  O_selB,  3'd5);
    chk("add_regwe", O_regwe, 1'b1);
    drive(1'b0, 16'h0A54, 1'b0, 1'b0, 3'd0);
    chk("idle_en",    O_en,    1'b0);
    chk("idle_regwe", O_regwe, 1'b0);
    chk("idle_selD",  O_selD,  3'd5);

    // Load with flag set
    drive(1'b1, 16'h83AB, 1'b0, 1'b0, 3'd0);
    chk("load_aluop", O_aluop, 5'b10001);
    chk("load_imm",   O_imm,   8'hAB);
    chk("load_regwe", O_regwe, 1'b1);

    // JMPR
    drive(1'b1, 16'hD000, 1'b0, 1'b0, 3'd0);
    chk("jmpr_en",    O_en,    1'b1);
    chk("jmpr_aluop", O_aluop, 5'b11010);
    chk("jmpr_regwe", O_regwe, 1'b0);

    // Back-to-back stream, then retire everything that may be pending.
    foreach (stream[i]) drive(1'b1, stream[i], 1'b0, 1'b0, 3'd0);
    for (int r = 0; r < 8; r++) drive(1'b0, 16'h0000, 1'b0, 1'b1, 3'(r));

    // Flush blocks acceptance.
    I_instr_valid = 1'b1; I_instr = 16'h1828; I_flush = 1'b1; I_wb_valid = 1'b0;
    #1;
    chk("flush_ready", O_instr_ready, 1'b0);
    @(posedge I_clk); #1;
    chk("flush_en", O_en, 1'b0);

    // Undefined opcode: consumed, not executed, sticky flag.
    drive(1'b1, 16'h7000, 1'b0, 1'b0, 3'd0);
    chk("ill_en",    O_en,      1'b0);
    chk("ill_regwe", O_regwe,   1'b0);
    chk("ill_flag",  O_illegal, 1'b1);
    drive(1'b1, 16'h0A54, 1'b0, 1'b0, 3'd0);
    chk("ill_next_en", O_en,      1'b1);
    chk("ill_sticky",  O_illegal, 1'b1);

    // Sub r5 <- r5, r5 collides with pending r5 when tracking; reset mid-cycle.
    I_instr_valid = 1'b1; I_instr = 16'h1AB4; I_flush = 1'b0;
    #1;
    chk("haz_ready", O_instr_ready, SB ? 1'b0 : 1'b1);
    #1 I_rst_n = 1'b0;
    #1;
    chk("arst_en",      O_en,          1'b0);
    chk("arst_illegal", O_illegal,     1'b0);
    chk("arst_aluop",   O_aluop,       5'd0);
    chk("arst_selD",    O_selD,        3'd0);
    chk("arst_imm",     O_imm,         8'd0);
    chk("arst_ready",   O_instr_ready, 1'b1);
    @(negedge I_clk);
    #2 I_rst_n = 1'b1;
    @(posedge I_clk); #1;
    chk("post_rst_en",    O_en,    1'b1);
    chk("post_rst_aluop", O_aluop, 5'b00010);

`ifdef DECODE_SCOREBOARD_EN
    drive(1'b0, 16'h0000, 1'b0, 1'b1, 3'd5);
    // Add r1 <- r2, r3 then dependent Sub r4 <- r1, r2
    drive(1'b1, 16'h024C, 1'b0, 1'b0, 3'd0);
    chk("sb_prod_en", O_en, 1'b1);
    I_instr = 16'h1828;
    #1;
    chk("sb_stall0", O_instr_ready, 1'b0);
    drive(1'b1, 16'h1828, 1'b0, 1'b0, 3'd0);
    chk("sb_wait_en", O_en,          1'b0);
    chk("sb_stall1",  O_instr_ready, 1'b0);
    drive(1'b1, 16'h1828, 1'b0, 1'b1, 3'd1);
    chk("sb_wb_en",   O_en,          1'b0);
    chk("sb_release", O_instr_ready, 1'b1);
    drive(1'b1, 16'h1828, 1'b0, 1'b0, 3'd0);
    chk("sb_cons_en",    O_en,    1'b1);
    chk("sb_cons_aluop", O_aluop, 5'b00010);
    chk("sb_cons_selD",  O_selD,  3'd4);
    // NOT r6 <- r4 must wait on the pending r4; flush leaves that pending.
    drive(1'b1, 16'h5C80, 1'b1, 1'b0, 3'd0);
    I_flush = 1'b0;
    #1;
    chk("sb_flush_busy", O_instr_ready, 1'b0);
    drive(1'b1, 16'h5C80, 1'b0, 1'b1, 3'd4);
    drive(1'b1, 16'h5C80, 1'b0, 1'b0, 3'd0);
    chk("sb_not_en", O_en, 1'b1);
`endif

    drive(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
# instr_decode

Instruction decode stage directly upstream of the ALU in the 16-bit RISC datapath. It accepts one 16-bit instruction per handshake and splits it into ALU opcode, register selects, immediate and write-enable. It issues a registered one-cycle ALU enable pulse. An optional register scoreboard stalls issue on read-after-write and write-after-write hazards until writeback retires the pending destination.

## Interface
- No parameters. Instruction width is fixed at 16 bits, 8 registers, 8-bit immediate.
- I_clk  in  1  clock. All state updates on the rising edge. The ALU samples outputs on the following falling edge.
- I_rst_n  in  1  asynchronous, active-low reset.
- I_instr_valid  in  1  fetch presents an instruction.
- I_instr  in  16  instruction word.
- O_instr_ready  out  1  decode accepts I_instr this cycle.
- I_flush  in  1  branch taken. Discard any accept this cycle.
- I_wb_valid  in  1  writeback retires a register write.
- I_wb_sel  in  3  register being retired.
- O_en  out  1  ALU enable. One-cycle pulse per issued instruction.
- O_aluop  out  5  {opcode[3:0], flag}.
- O_selD / O_selA / O_selB  out  3 each  destination, source A and source B selects.
- O_imm  out  8  immediate.
- O_regwe  out  1  the issued instruction writes O_selD.
- O_illegal  out  1  sticky flag for an undefined opcode.

## Operation
- Field map:
  - opcode = I_instr[15:12]
  - rD = [11:9]
  - flag = [8]
  - rA = [7:5]
  - rB = [4:2]
  - imm = [7:0]
- Defined opcodes: Add 0, Sub 1, OR 2, AND 3, XOR 4, NOT 5, Load 8, Cmp 9, SHL 10, SHR 11, JMPA 12, JMPR 13.
- Register writes:
  - O_regwe = 1 for opcodes 0–5 and 8–11.
  - O_regwe = 0 for JMPA and JMPR.
- Sources read:
  - Load reads none.
  - NOT reads rA.
  - JMPA reads rA only when flag = 1.
  - All others read rA and rB.
- Undefined opcodes (6, 7, 14, 15):
  - Accepted like any instruction but issued with O_en = 0 and O_regwe = 0.
  - O_illegal is set and held until reset.
- Accept condition: I_instr_valid && O_instr_ready && !I_flush.
  - Accept: output registers load the decoded fields, and O_en = 1 for one cycle.
  - No accept: O_en = 0 and O_regwe = 0. The other outputs hold their last values.
- O_instr_ready = !I_flush && !stall. Without the scoreboard, stall = 0.
- Scoreboard (busy[7:0]):
  - stall = 1 if any source read is busy, or if O_regwe would be 1 and rD is busy.
  - On issue with O_regwe = 1, busy[rD] is set.
  - On I_wb_valid, busy[I_wb_sel] is cleared.
  - Set and clear of the same bit in the same cycle: set wins.
  - No bypass. A clear becomes visible to the stall check on the next cycle.
  - I_wb_valid on a non-busy register is ignored.
- I_flush does not alter busy bits; already-issued instructions still retire.

## Timing
- Reset values (asynchronous):
  - O_en, O_regwe, O_illegal, O_aluop, O_selD/A/B, O_imm = 0.
  - busy = 0.
  - O_instr_ready = 1 once I_rst_n is high, unless I_flush is asserted.
- Latency: instruction accepted at rising edge N; decoded outputs and O_en valid from edge N until edge N+1. The ALU consumes them on the falling edge inside that cycle.
- Throughput: one instruction per cycle when no stall occurs.
- Minimum stall for a dependent back-to-back pair:
  - Producer issues at edge N.
  - Consumer issues no earlier than one edge after the I_wb_valid edge.
- Reset mid-stall clears busy; the next valid instruction is accepted on the first edge after release.

## Configuration
- DECODE_SCOREBOARD_EN:
  - Defined: busy[7:0] and hazard stall logic as above.
  - Undefined: no busy state, stall = 0, and I_wb_valid / I_wb_sel are ignored. Hazard ordering is then the software's responsibility.

## Test plan
- Reset, then I_instr = 16'h0A54 with valid → next cycle:
  - O_en = 1, O_aluop = 5'b00000, O_selD = 5, O_selA = 2, O_selB = 5, O_regwe = 1.
  - O_en = 0 the cycle after.
- Load high: I_instr = 16'h83AB → O_aluop = 5'b10001, O_imm = 8'hAB, O_regwe = 1.
- JMPR: I_instr = 16'hD000 → O_aluop = 5'b11010, O_regwe = 0.
- Scoreboard (macro defined):
  - Issue Add r1←r2,r3, then present Sub r4←r1,r2 → O_instr_ready = 0 until the cycle after I_wb_valid with I_wb_sel = 1.
  - Sub then issues exactly one cycle later.
- Undefined opcode: I_instr = 16'h7000 → O_en stays 0, O_illegal = 1 and stays 1 across further valid instructions until I_rst_n is pulsed.
- Flush and reset:
  - I_flush = 1 with valid instruction → not accepted, O_en = 0 next cycle, busy unchanged.
  - Asserting I_rst_n = 0 mid-stall → all outputs and busy return to 0 immediately.
